// File: rtl/vram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_pkg                                                           |
// | Default geometry, word format and FSM encoding for vram_arbiter.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vram_pkg;

  localparam int              DEF_FB_W        = 320;
  localparam int              DEF_FB_H        = 200;
  localparam int              DEF_SCALE_SHIFT = 2;
  localparam int              DEF_ADDR_W      = 16;
  localparam int              DEF_DATA_W      = 12;
  localparam logic [11:0]     DEF_CLEAR_COLOR = 12'h000;
  localparam int              DEF_FB_WORDS    = DEF_FB_W * DEF_FB_H;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vram_addr_calc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_addr_calc                                                     |
// | Maps a scaled screen position to a framebuffer word address.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vram_addr_calc
  import vram_pkg::*;
#(
  parameter int FB_W        = DEF_FB_W,
  parameter int FB_H        = DEF_FB_H,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic [10:0]       x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  logic [9:0]  row;
  logic [10:0] col;

  // Constant multiplier: synthesis reduces row*FB_W to shift-add.
  always_comb begin
    row      = y >> SCALE_SHIFT;
    col      = x >> SCALE_SHIFT;
    in_range = 32'(row) < 32'(FB_H);
    addr     = ADDR_W'(row) * ADDR_W'(FB_W) + ADDR_W'(col);
  end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_arbiter                                                       |
// | Single-port framebuffer sharing: fixed display slots, clear engine,|
// | draw port on free cycles. VRAM_ARB_STATS_EN adds debug counters.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int                FB_W        = DEF_FB_W,
  parameter int                FB_H        = DEF_FB_H,
  parameter int                SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = DATA_W'(DEF_CLEAR_COLOR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       disp_x,
  input  logic [9:0]        disp_y,
  input  logic              disp_vis,
  output logic [DATA_W-1:0] disp_rgb,
  input  logic              draw_valid,
  output logic              draw_ready,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       dbg_stall_cnt,
  output logic [15:0]       dbg_frame_cnt
`endif
);

  localparam int                FB_WORDS  = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  logic [ADDR_W-1:0] slot_addr;
  logic              slot_in_range, slot, draw_hs, draw_in_fb;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
  logic              clear_busy_q, clear_busy_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              fetch1_q, fetch1_d, fetch2_q, fetch2_d;
  logic              show1_q, show1_d, show2_q, show2_d;
  logic              rd1_q, rd1_d, rd2_q, rd2_d, oob1_q, oob1_d, oob2_q, oob2_d;
  logic [DATA_W-1:0] pix_q, pix_d, disp_rgb_q, disp_rgb_d;
  logic              draw_rvalid_q, draw_rvalid_d;
  logic [DATA_W-1:0] draw_rdata_q, draw_rdata_d;

  vram_addr_calc #(
    .FB_W        (FB_W),
    .FB_H        (FB_H),
    .SCALE_SHIFT (SCALE_SHIFT),
    .ADDR_W      (ADDR_W)
  ) u_slot_addr (
    .x        (disp_x),
    .y        (disp_y),
    .addr     (slot_addr),
    .in_range (slot_in_range)
  );

  always_comb begin
    slot       = disp_vis && (disp_x[SCALE_SHIFT-1:0] == '0) && slot_in_range;
    draw_ready = (state_q == ST_RUN) && !slot;
    draw_hs    = draw_valid && draw_ready;
    draw_in_fb = 32'(draw_addr) < 32'(FB_WORDS);

    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    rd1_d        = 1'b0;
    oob1_d       = 1'b0;

    // Priority: display slot, then clear engine, then draw port.
    if (slot) begin
      mem_en_d   = 1'b1;
      mem_addr_d = slot_addr;
    end else if (state_q == ST_CLEAR) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = clear_addr_q;
      mem_wdata_d = CLEAR_COLOR;
      if (clear_addr_q == LAST_ADDR) state_d = ST_RUN;
      else                           clear_addr_d = clear_addr_q + ADDR_W'(1);
    end else if (draw_hs) begin
      mem_en_d    = draw_in_fb;
      mem_we_d    = draw_we && draw_in_fb;
      mem_addr_d  = draw_addr;
      mem_wdata_d = draw_wdata;
      rd1_d       = !draw_we;
      oob1_d      = !draw_in_fb;
    end

    // A draw accepted in this same cycle is already issued above.
    if (state_q == ST_RUN && clear_req) begin
      state_d      = ST_CLEAR;
      clear_addr_d = '0;
    end
    clear_busy_d = (state_d == ST_CLEAR);

    fetch1_d      = slot;
    show1_d       = disp_vis && slot_in_range;
    fetch2_d      = fetch1_q;
    show2_d       = show1_q;
    rd2_d         = rd1_q;
    oob2_d        = oob1_q;
    pix_d         = fetch2_q ? mem_rdata : pix_q;
    disp_rgb_d    = show2_q ? pix_d : '0;
    draw_rvalid_d = rd2_q;
    draw_rdata_d  = (rd2_q && !oob2_q) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      clear_addr_q  <= '0;
      clear_busy_q  <= 1'b1;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fetch1_q      <= 1'b0;
      fetch2_q      <= 1'b0;
      show1_q       <= 1'b0;
      show2_q       <= 1'b0;
      rd1_q         <= 1'b0;
      rd2_q         <= 1'b0;
      oob1_q        <= 1'b0;
      oob2_q        <= 1'b0;
      pix_q         <= '0;
      disp_rgb_q    <= '0;
      draw_rvalid_q <= 1'b0;
      draw_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      clear_addr_q  <= clear_addr_d;
      clear_busy_q  <= clear_busy_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch1_q      <= fetch1_d;
      fetch2_q      <= fetch2_d;
      show1_q       <= show1_d;
      show2_q       <= show2_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      oob1_q        <= oob1_d;
      oob2_q        <= oob2_d;
      pix_q         <= pix_d;
      disp_rgb_q    <= disp_rgb_d;
      draw_rvalid_q <= draw_rvalid_d;
      draw_rdata_q  <= draw_rdata_d;
    end
  end

  assign disp_rgb    = disp_rgb_q;
  assign draw_rvalid = draw_rvalid_q;
  assign draw_rdata  = draw_rdata_q;
  assign clear_busy  = clear_busy_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, frame_cnt_q, frame_cnt_d;
  logic        vis_prev_q, vis_prev_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    frame_cnt_d = frame_cnt_q;
    vis_prev_d  = disp_vis;
    if (draw_valid && !draw_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (disp_vis && !vis_prev_q && disp_x == '0 && disp_y == '0)
      frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      frame_cnt_q <= '0;
      vis_prev_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      vis_prev_q  <= vis_prev_d;
    end
  end

  assign dbg_stall_cnt = stall_cnt_q;
  assign dbg_frame_cnt = frame_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vram_arbiter                                                    |
// | Directed bench on an 8x4 framebuffer, scale shift 2, BRAM model.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_vram_arbiter;

  localparam int          FB_W  = 8;
  localparam int          FB_H  = 4;
  localparam int          WORDS = FB_W * FB_H;
  localparam logic [11:0] CC    = 12'h3C6;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] disp_x;
  logic [9:0]  disp_y;
  logic        disp_vis;
  logic [11:0] disp_rgb;
  logic        draw_valid, draw_ready, draw_we, draw_rvalid;
  logic [15:0] draw_addr;
  logic [11:0] draw_wdata, draw_rdata;
  logic        clear_req, clear_busy;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [11:0] mem_wdata, mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] dbg_stall_cnt, dbg_frame_cnt;
`endif

  always #5 clk = ~clk;

  vram_arbiter #(
    .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(2), .ADDR_W(16), .DATA_W(12), .CLEAR_COLOR(CC)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_x(disp_x), .disp_y(disp_y), .disp_vis(disp_vis), .disp_rgb(disp_rgb),
    .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_we(draw_we),
    .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_rvalid(draw_rvalid), .draw_rdata(draw_rdata),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    , .dbg_stall_cnt(dbg_stall_cnt), .dbg_frame_cnt(dbg_frame_cnt)
`endif
  );

  // BRAM model with a write log and an out-of-range access counter.
  logic [11:0] bram [0:31];
  logic [11:0] rdata_q;
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [11:0] pre_data = '0;
  int          wr_total = 0;
  int          oob_cnt = 0;
  logic [15:0] wlog_addr [0:127];
  logic [11:0] wlog_data [0:127];

  always @(posedge clk) begin
    if (pre_we) bram[pre_addr] <= pre_data;
    if (mem_en) begin
      if (mem_addr >= 16'(WORDS)) oob_cnt <= oob_cnt + 1;
      else if (mem_we) begin
        bram[mem_addr[4:0]]        <= mem_wdata;
        wlog_addr[wr_total % 128]  <= mem_addr;
        wlog_data[wr_total % 128]  <= mem_wdata;
        wr_total                   <= wr_total + 1;
      end else rdata_q <= bram[mem_addr[4:0]];
    end
  end
  assign mem_rdata = rdata_q;

  typedef struct {
    int          due;
    logic [11:0] val;
  } exp_t;

  exp_t        dq[$];
  exp_t        rq[$];
  logic [11:0] shadow [0:31];
  int          total = 0, bad = 0, cyc = 0;
  bit          run_mode = 1'b0;
  bit          hs;
  int          n, mark, hs_x, mism;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    while (dq.size() > 0 && dq[0].due <= cyc) begin
      chk("disp_rgb", 32'(disp_rgb), 32'(dq[0].val));
      void'(dq.pop_front());
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("draw_rvalid", 32'(draw_rvalid), 32'd1);
      chk("draw_rdata", 32'(draw_rdata), 32'(rq[0].val));
      void'(rq.pop_front());
    end else begin
      chk("draw_rvalid_idle", 32'(draw_rvalid), 32'd0);
    end
  endtask

  task automatic step(input bit vis, input int x, input int y, input bit dv, input bit we,
                      input int addr, input logic [11:0] wd, input bit creq, output bit hs_o);
    int          row, col;
    bit          slot;
    logic [11:0] e;
    disp_vis   = vis;
    disp_x     = 11'(x);
    disp_y     = 10'(y);
    draw_valid = dv;
    draw_we    = we;
    draw_addr  = 16'(addr);
    draw_wdata = wd;
    clear_req  = creq;
    row  = y >> 2;
    col  = x >> 2;
    e    = (vis && row < FB_H) ? shadow[row*FB_W + col] : 12'h000;
    dq.push_back('{cyc + 3, e});
    slot = vis && (x % 4 == 0) && (row < FB_H);
    #3;
    chk("draw_ready", 32'(draw_ready), 32'(run_mode && !slot));
    hs_o = dv && draw_ready;
    if (hs_o && !we) rq.push_back('{cyc + 3, (addr < WORDS) ? shadow[addr] : 12'h000});
    if (hs_o && we && addr < WORDS) shadow[addr] = wd;
    tick();
  endtask

  task automatic idle(input int cnt);
    bit h;
    for (int i = 0; i < cnt; i++) step(0, 0, 0, 0, 0, 0, 12'h000, 0, h);
  endtask

  task automatic preload(input int a, input logic [11:0] d);
    bit h;
    pre_we   = 1'b1;
    pre_addr = 5'(a);
    pre_data = d;
    step(0, 0, 0, 0, 0, 0, 12'h000, 0, h);
    pre_we   = 1'b0;
    shadow[a] = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_clear_busy"}, 32'(clear_busy), 32'd1);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_draw_ready"}, 32'(draw_ready), 32'd0);
    chk({tag, "_draw_rdata"}, 32'(draw_rdata), 32'd0);
    chk({tag, "_disp_rgb"}, 32'(disp_rgb), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    disp_vis = 0; disp_x = '0; disp_y = '0;
    draw_valid = 0; draw_we = 0; draw_addr = '0; draw_wdata = '0; clear_req = 0;
    @(posedge clk); @(posedge clk); #1;

    // 1: reset values, garbage fill, then clear with no display traffic
    check_reset_outputs("reset");
    for (int i = 0; i < WORDS; i++) preload(i, 12'hE00 | 12'(i));
    rst = 1'b0;
    n = 0;
    while (clear_busy === 1'b1 && n < 200) begin
      n++;
      idle(1);
    end
    chk("clear_len", 32'(n), 32'd32);
    run_mode = 1'b1;
    idle(1);
    mism = 0;
    for (int i = 0; i < WORDS; i++) if (bram[i] !== CC) mism++;
    chk("bram_cleared", 32'(mism), 32'd0);
    for (int i = 0; i < WORDS; i++) shadow[i] = CC;

    // 2: preloaded word at row 1 col 1 appears for x=4..7 on y=4
    preload(9, 12'h5A3);
    for (int i = 0; i < FB_W; i++) preload(i, 12'h100 + 12'(i));
    for (int x = 0; x < 32; x++) step(1, x, 4, 0, 0, 0, 12'h000, 0, hs);
    idle(4);

    // 3: draw write held from a slot cycle during a visible line
    mark = wr_total;
    hs_x = -1;
    for (int x = 0; x < 32; x++) begin
      step(1, x, 0, (x >= 4 && hs_x < 0), 1, 10, 12'hFFF, 0, hs);
      if (hs && hs_x < 0) hs_x = x;
    end
    idle(4);
    chk("stall_accept_x", 32'(hs_x), 32'd5);
    chk("one_write", 32'(wr_total - mark), 32'd1);
    chk("write_addr", 32'(wlog_addr[mark % 128]), 32'd10);
    chk("write_data", 32'(wlog_data[mark % 128]), 32'hFFF);
    // rows beyond FB_H produce no slots and black pixels
    for (int x = 0; x < 8; x++) step(1, x, 16, 0, 0, 0, 12'h000, 0, hs);

    // 4: reads, in-range and out-of-range, and a dropped out-of-range write
    step(0, 0, 0, 1, 0, 10, 12'h000, 0, hs);
    chk("rd_accept", 32'(hs), 32'd1);
    idle(4);
    mark = wr_total;
    step(0, 0, 0, 1, 0, 40, 12'h000, 0, hs);
    step(0, 0, 0, 1, 1, 40, 12'h0AB, 0, hs);
    idle(4);
    chk("oob_no_mem_en", 32'(oob_cnt), 32'd0);
    chk("oob_write_dropped", 32'(wr_total - mark), 32'd0);

    // 5: clear_req alongside a draw write; a second request mid-clear
    mark = wr_total;
    step(0, 0, 0, 1, 1, 5, 12'h777, 1, hs);
    chk("clr_draw_accept", 32'(hs), 32'd1);
    run_mode = 1'b0;
    n = 0;
    while (clear_busy === 1'b1 && n < 200) begin
      n++;
      step(0, 0, 0, 1, 0, 3, 12'h000, (n == 10), hs);
    end
    chk("clear_len_rereq", 32'(n), 32'd32);
    run_mode = 1'b1;
    idle(1);
    chk("first_write_addr", 32'(wlog_addr[mark % 128]), 32'd5);
    chk("first_write_data", 32'(wlog_data[mark % 128]), 32'h777);
    chk("second_write_addr", 32'(wlog_addr[(mark + 1) % 128]), 32'd0);
    chk("clear_write_count", 32'(wr_total - mark), 32'd33);
    chk("addr5_overwritten", 32'(bram[5]), 32'(CC));
    for (int i = 0; i < WORDS; i++) shadow[i] = CC;

    // 6: reset mid-clear restarts at 0; display slots lengthen the clear
    step(0, 0, 0, 0, 0, 0, 12'h000, 1, hs);
    run_mode = 1'b0;
    idle(17);
    chk("pre_rst_mem_addr", 32'(mem_addr), 32'd16);
    rst = 1'b1;
    idle(1);
    check_reset_outputs("midclear_reset");
    rst = 1'b0;
    mark = wr_total;
    n = 0;
    while (clear_busy === 1'b1 && n < 200) begin
      step((n < 16), n, 0, 0, 0, 0, 12'h000, 0, hs);
      n++;
    end
    chk("clear_len_slots", 32'(n), 32'd36);
    chk("restart_addr", 32'(wlog_addr[mark % 128]), 32'd0);
    run_mode = 1'b1;
    idle(4);

    for (int i = 0; i < 3; i++) tick();
    chk("disp_queue_drained", 32'(dq.size()), 32'd0);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
